// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divisor_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Default operand / quotient / remainder width
    localparam int DIVISOR_WIDTH_DEF = 4;

    // Quotient reported on divide-by-zero: all ones, sliced to WIDTH by the user
    localparam logic [63:0] COCIENTE_DIV0 = '1;

endpackage : divisor_pkg

// File: rtl/restador4bits.sv
// Combinational unsigned subtractor: diferencia = a - b, borrow set when a < b.
module restador4bits
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIVISOR_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diferencia,
    output logic             borrow
);

    logic [WIDTH:0] resta_ext;

    // Zero-extend both operands so the extra MSB of the result is the borrow
    always_comb begin
        resta_ext  = {1'b0, a} - {1'b0, b};
        diferencia = resta_ext[WIDTH-1:0];
        borrow     = resta_ext[WIDTH];
    end

endmodule : restador4bits

// File: rtl/divisor_secuencial4bits.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero is resolved here directly
// RUN   | one restoring iteration per cycle, WIDTH cycles in total
// DONE  | results valid and done pulsed for this single cycle
module divisor_secuencial4bits
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIVISOR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             div_cero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ULTIMA_ITER = CW'(WIDTH - 1);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] divq_q, divq_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] coc_q, coc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dz_q, dz_d;

    logic [WIDTH+1:0] desplazado;
    logic [WIDTH-1:0] diferencia;
    logic             borrow;
    logic             cabe;
    logic [WIDTH:0]   quo_ext;

    // Remainder shifted left with the next dividend bit appended. The shifted
    // value can need WIDTH+1 bits; when its top bit is set it is already at
    // least 2^WIDTH, so it always exceeds the divisor and the WIDTH-bit
    // difference of the low bits is still the exact new remainder.
    always_comb begin
        desplazado = {rem_q, work_q[WIDTH-1]};
        cabe       = (|desplazado[WIDTH+1:WIDTH]) | ~borrow;
        quo_ext    = {quo_q, cabe};
    end

    restador4bits #(
        .WIDTH (WIDTH)
    ) u_restador (
        .a          (desplazado[WIDTH-1:0]),
        .b          (divq_q),
        .diferencia (diferencia),
        .borrow     (borrow)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        divq_d  = divq_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        coc_d   = coc_q;
        res_d   = res_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        work_d  = dividendo;
                        divq_d  = divisor;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        coc_d   = COCIENTE_DIV0[WIDTH-1:0];
                        res_d   = dividendo;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                work_d = work_q << 1;
                rem_d  = cabe ? {1'b0, diferencia} : desplazado[WIDTH:0];
                quo_d  = quo_ext[WIDTH-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ULTIMA_ITER) begin
                    coc_d   = quo_d;
                    res_d   = rem_d[WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            divq_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            coc_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            divq_q  <= divq_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            coc_q   <= coc_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    // Status and result outputs decoded from registered state
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        cociente = coc_q;
        residuo  = res_q;
        div_cero = dz_q;
    end

endmodule : divisor_secuencial4bits

// File: tb/tb_divisor_secuencial4bits.sv
// Directed bench for the sequential restoring divider.
module tb_divisor_secuencial4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividendo;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] cociente;
    logic [3:0] residuo;
    logic       div_cero;

    int checks;
    int errors;

    divisor_secuencial4bits #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .cociente  (cociente),
        .residuo   (residuo),
        .div_cero  (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division, measure latency to done, check results and the
    // cycle after done.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           input int exp_q, input int exp_r, input int exp_z,
                           input int exp_lat);
        int lat;
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check($sformatf("latency %0d/%0d", a, b), lat, exp_lat);
        check($sformatf("cociente %0d/%0d", a, b), int'(cociente), exp_q);
        check($sformatf("residuo %0d/%0d", a, b), int'(residuo), exp_r);
        check($sformatf("div_cero %0d/%0d", a, b), int'(div_cero), exp_z);
        check($sformatf("busy_in_done %0d/%0d", a, b), int'(busy), 1);
        step();
        check($sformatf("done_low_after %0d/%0d", a, b), int'(done), 0);
        check($sformatf("busy_low_after %0d/%0d", a, b), int'(busy), 0);
        check($sformatf("cociente_hold %0d/%0d", a, b), int'(cociente), exp_q);
    endtask

    initial begin
        int lat;
        int pulses;
        int eq;
        int er;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividendo = 4'd0;
        divisor   = 4'd0;
        step();
        step();

        // Reset state
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_cociente", int'(cociente), 0);
        check("reset_residuo", int'(residuo), 0);
        check("reset_div_cero", int'(div_cero), 0);
        rst_n = 1'b1;
        step();

        // Basic divisions
        run_div(4'd13, 4'd3, 4, 1, 0, 5);
        run_div(4'd15, 4'd1, 15, 0, 0, 5);
        run_div(4'd2, 4'd7, 0, 2, 0, 5);
        run_div(4'd9, 4'd0, 15, 9, 1, 1);
        run_div(4'd8, 4'd2, 4, 0, 0, 5);

        // start pulse with new operands mid-RUN is ignored
        dividendo = 4'd13;
        divisor   = 4'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        step();
        lat++;
        dividendo = 4'd1;
        divisor   = 4'd1;
        start     = 1'b1;
        step();
        lat++;
        start = 1'b0;
        check("midrun_busy", int'(busy), 1);
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("midrun_latency", lat, 5);
        check("midrun_cociente", int'(cociente), 4);
        check("midrun_residuo", int'(residuo), 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) pulses++;
        end
        check("midrun_extra_done", pulses, 0);
        check("midrun_cociente_hold", int'(cociente), 4);
        check("midrun_residuo_hold", int'(residuo), 1);

        // Reset in the third RUN cycle abandons the operation
        dividendo = 4'd13;
        divisor   = 4'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n     = 1'b0;
        start     = 1'b1;
        dividendo = 4'd5;
        divisor   = 4'd1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cociente", int'(cociente), 0);
        check("rst_residuo", int'(residuo), 0);
        check("rst_div_cero", int'(div_cero), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) pulses++;
        end
        check("rst_no_activity", pulses, 0);
        run_div(4'd6, 4'd4, 1, 2, 0, 5);

        // Exhaustive sweep against an arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 15;
                    er = a;
                end else begin
                    eq = a / b;
                    er = a % b;
                end
                run_div(4'(a), 4'(b), eq, er, (b == 0) ? 1 : 0, (b == 0) ? 1 : 5);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_divisor_secuencial4bits

// File: doc/divisor_secuencial4bits.md
DIVISOR_SECUENCIAL4BITS -- requirements
Module: divisor_secuencial4bits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-005 The block SHALL have port dividendo, input, WIDTH bits: unsigned dividend, latched when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor, latched when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port cociente, output, WIDTH bits: quotient result.
REQ-010 The block SHALL have port residuo, output, WIDTH bits: remainder result.
REQ-011 The block SHALL have port div_cero, output, 1 bit: the last division had divisor zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 and divisor!=0 SHALL:
- latch both operands;
- clear the working remainder and the iteration counter;
- move to RUN.
REQ-014 IDLE with start=1 and divisor=0 SHALL go directly to DONE and register:
- cociente = all ones;
- residuo = dividendo;
- div_cero = 1.
REQ-015 RUN SHALL perform one restoring iteration per cycle, MSB of dividend first:
- shift the working remainder left one bit;
- append the next dividend bit;
- subtract the divisor via the sub-module;
- if no borrow: keep the difference and set the quotient bit to 1;
- otherwise: restore the remainder and set the quotient bit to 0.
REQ-016 Remainder arithmetic SHALL use WIDTH+1 bits internally so the shifted remainder never overflows.
REQ-017 After exactly WIDTH iterations, RUN SHALL register cociente and residuo, clear div_cero and move to DONE.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE, then the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be:
- divisor!=0: done high WIDTH+1 cycles after the cycle in which start was sampled high;
- divisor=0: done high 1 cycle after that cycle.
REQ-020 start SHALL be ignored in RUN and DONE; the in-flight operation SHALL be unaffected.
REQ-021 Operand input changes after acceptance SHALL NOT affect the result.
REQ-022 cociente, residuo and div_cero SHALL hold their values until the next completion or reset.
REQ-023 Results SHALL satisfy dividendo = cociente*divisor + residuo with residuo < divisor for every divisor!=0.

Reset
REQ-024 rst_n=0 at a rising clk edge SHALL force, on any cycle including mid-RUN:
- state IDLE;
- busy=0, done=0;
- cociente=0, residuo=0, div_cero=0;
- counter and working registers cleared.
REQ-025 An operation interrupted by reset SHALL be abandoned with no done pulse.
REQ-026 start SHALL be ignored in any cycle where rst_n=0.

Structure
REQ-027 A shared package divisor_pkg SHALL hold:
- the state enum typedef (IDLE, RUN, DONE);
- the default WIDTH constant;
- the divide-by-zero quotient constant (all ones).
REQ-028 One sub-module restador4bits SHALL be instantiated:
- combinational WIDTH-bit subtractor;
- outputs difference and borrow;
- the counterpart of the team's ripple adder.
REQ-029 The iteration counter SHALL be clog2(WIDTH)+1 bits wide.

Verification
REQ-030 dividendo=13, divisor=3, start pulse -> done exactly 5 cycles later, cociente=4, residuo=1, div_cero=0.
REQ-031 15/1 -> cociente=15, residuo=0; then 2/7 -> cociente=0, residuo=2, each with 5-cycle latency.
REQ-032 9/0 -> done 1 cycle later, cociente=15, residuo=9, div_cero=1; then 8/2 -> cociente=4, residuo=0, div_cero=0.
REQ-033 Start 13/3, pulse start=1 with 1/1 in cycle 2 of RUN -> only one done pulse, result 4/1; outputs unchanged afterwards.
REQ-034 Start 13/3, assert rst_n=0 in cycle 3 of RUN -> all outputs 0, no done pulse; a new 6/4 request then gives cociente=1, residuo=2.
REQ-035 Exhaustive sweep over all 256 operand pairs -> every result matches the REQ-019 latency and REQ-023 invariant, with divisor-zero cases per REQ-014.
